// File: rtl/apb4_cpuif_responder_pkg.sv
// Shared state encoding and helpers for the APB4 CPU-interface responder.
package apb4_cpuif_responder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } state_e;

    localparam int DEFAULT_DATA_WIDTH = 32;

    function automatic int addr_lsb(input int data_width);
        return $clog2(data_width / 8);
    endfunction

    localparam int ADDR_LSB = addr_lsb(DEFAULT_DATA_WIDTH);

    // One byte strobe expands to eight bit enables.
    function automatic logic [7:0] strb_to_biten(input logic strb);
        return {8{strb}};
    endfunction

endpackage

// File: rtl/apb4_cpuif_timeout_ctr.sv
// Clear/enable cycle counter that pulses tc on the last counted cycle.
module cpuif_timeout_ctr #(
    parameter int TERMINAL = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic tc
);
    localparam int CW = (TERMINAL > 1) ? $clog2(TERMINAL) : 1;
    localparam logic [CW-1:0] LAST = CW'(TERMINAL - 1);

    logic [CW-1:0] count_r;

    // Count cycles while enabled; clear has priority.
    always_ff @(posedge clk) begin
        if (!rst) begin
            count_r <= '0;
        end else if (clear) begin
            count_r <= '0;
        end else if (enable) begin
            count_r <= count_r + {{(CW-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    assign tc = enable && (count_r == LAST);

endmodule

// File: rtl/apb4_cpuif_responder.sv
// APB4 completer that drives the regblock's single-outstanding CPU interface,
// with a bounded response time so a lost internal ack cannot hang the bus.
module apb4_cpuif_responder
    import apb4_cpuif_responder_pkg::*;
#(
    parameter int ADDR_WIDTH     = 12,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    s_apb_psel,
    input  logic                    s_apb_penable,
    input  logic                    s_apb_pwrite,
    input  logic [ADDR_WIDTH-1:0]   s_apb_paddr,
    input  logic [DATA_WIDTH-1:0]   s_apb_pwdata,
    input  logic [DATA_WIDTH/8-1:0] s_apb_pstrb,
    input  logic [2:0]              s_apb_pprot,
    output logic                    s_apb_pready,
    output logic [DATA_WIDTH-1:0]   s_apb_prdata,
    output logic                    s_apb_pslverr,
    output logic                    cpuif_req,
    output logic                    cpuif_req_is_wr,
    output logic [ADDR_WIDTH-1:0]   cpuif_addr,
    output logic [DATA_WIDTH-1:0]   cpuif_wr_data,
    output logic [DATA_WIDTH-1:0]   cpuif_wr_biten,
    input  logic                    cpuif_req_stall_wr,
    input  logic                    cpuif_req_stall_rd,
    input  logic                    cpuif_rd_ack,
    input  logic                    cpuif_rd_err,
    input  logic [DATA_WIDTH-1:0]   cpuif_rd_data,
    input  logic                    cpuif_wr_ack,
    input  logic                    cpuif_wr_err
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int LSB = addr_lsb(DATA_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] LSB_MASK = ADDR_WIDTH'((64'd1 << LSB) - 64'd1);

    state_e                  state_r, state_next_s;
    logic                    orphan_r, orphan_next_s;
    logic                    is_wr_r;
    logic [ADDR_WIDTH-1:0]   addr_r;
    logic [DATA_WIDTH-1:0]   wdata_r, biten_r, biten_s;
    logic                    pready_r, pslverr_r;
    logic [DATA_WIDTH-1:0]   prdata_r;
    logic                    setup_s, req_s, stall_s, ack_s, err_s, any_ack_s, accept_s;
    logic                    go_resp_s, resp_err_s, timeout_s, ctr_clear_s, ctr_en_s;
    logic [DATA_WIDTH-1:0]   resp_data_s;
    logic                    unused_pprot_s;

    assign unused_pprot_s = ^s_apb_pprot;

    for (genvar i = 0; i < STRB_WIDTH; i++) begin : g_biten
        assign biten_s[i*8 +: 8] = strb_to_biten(s_apb_pstrb[i]);
    end

    assign setup_s   = s_apb_psel && !s_apb_penable;
    assign req_s     = (state_r == REQ) && !orphan_r;
    assign stall_s   = is_wr_r ? cpuif_req_stall_wr : cpuif_req_stall_rd;
    assign ack_s     = is_wr_r ? cpuif_wr_ack : cpuif_rd_ack;
    assign err_s     = is_wr_r ? cpuif_wr_err : cpuif_rd_err;
    assign any_ack_s = cpuif_rd_ack || cpuif_wr_ack;
    assign accept_s  = req_s && !stall_s;

    assign ctr_clear_s = (state_r == IDLE) && setup_s;
    assign ctr_en_s    = (state_r == REQ) || (state_r == WAIT);

    if (TIMEOUT_CYCLES > 0) begin : g_timeout
        cpuif_timeout_ctr #(.TERMINAL(TIMEOUT_CYCLES)) u_timeout (
            .clk    (clk),
            .rst    (rst),
            .clear  (ctr_clear_s),
            .enable (ctr_en_s),
            .tc     (timeout_s)
        );
    end else begin : g_no_timeout
        assign timeout_s = 1'b0;
    end

    // Next-state, response selection and orphan-ack bookkeeping.
    always_comb begin
        state_next_s  = state_r;
        go_resp_s     = 1'b0;
        resp_err_s    = 1'b0;
        resp_data_s   = '0;
        // Any ack seen while an abandoned request is outstanding belongs to it.
        orphan_next_s = orphan_r && !any_ack_s;
        case (state_r)
            IDLE: begin
                if (setup_s) begin
                    state_next_s = REQ;
                end else begin
                    state_next_s = IDLE;
                end
            end
            REQ: begin
                if (accept_s && ack_s) begin
                    go_resp_s   = 1'b1;
                    resp_err_s  = err_s;
                    resp_data_s = is_wr_r ? '0 : cpuif_rd_data;
                end else if (timeout_s) begin
                    go_resp_s     = 1'b1;
                    resp_err_s    = 1'b1;
                    orphan_next_s = orphan_next_s || accept_s;
                end else if (accept_s) begin
                    state_next_s = WAIT;
                end else begin
                    state_next_s = REQ;
                end
            end
            WAIT: begin
                if (ack_s) begin
                    go_resp_s   = 1'b1;
                    resp_err_s  = err_s;
                    resp_data_s = is_wr_r ? '0 : cpuif_rd_data;
                end else if (timeout_s) begin
                    go_resp_s     = 1'b1;
                    resp_err_s    = 1'b1;
                    orphan_next_s = 1'b1;
                end else begin
                    state_next_s = WAIT;
                end
            end
            RESP: begin
                state_next_s = IDLE;
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
        if (go_resp_s) begin
            state_next_s = RESP;
        end else begin
            state_next_s = state_next_s;
        end
    end

    // State, response registers and the request captured in the setup phase.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r   <= IDLE;
            orphan_r  <= 1'b0;
            is_wr_r   <= 1'b0;
            addr_r    <= '0;
            wdata_r   <= '0;
            biten_r   <= '0;
            pready_r  <= 1'b0;
            pslverr_r <= 1'b0;
            prdata_r  <= '0;
        end else begin
            state_r   <= state_next_s;
            orphan_r  <= orphan_next_s;
            pready_r  <= go_resp_s;
            pslverr_r <= go_resp_s && resp_err_s;
            prdata_r  <= resp_data_s;
            if (ctr_clear_s) begin
                is_wr_r <= s_apb_pwrite;
                addr_r  <= s_apb_paddr & ~LSB_MASK;
                wdata_r <= s_apb_pwdata;
                biten_r <= biten_s;
            end
        end
    end

    assign s_apb_pready    = pready_r;
    assign s_apb_prdata    = prdata_r;
    assign s_apb_pslverr   = pslverr_r;
    assign cpuif_req       = req_s;
    assign cpuif_req_is_wr = is_wr_r;
    assign cpuif_addr      = addr_r;
    assign cpuif_wr_data   = wdata_r;
    assign cpuif_wr_biten  = biten_r;

endmodule
